conv_row_pe_v2: RTL and testbench
=================================

Name: conv_row_pe_v2

Overview:
- Parametrised successor to the fixed 3-tap conv PE.
- Holds one KDIM-tap kernel row and streams one or more feature-map rows through a shift window, one output per valid window position.
- Runtime-selectable zero padding and stride 1/2; signed full-precision accumulation.
- Ready/valid handshakes on all streams with output backpressure; instantiated per kernel row inside the 2D conv accelerator array.

Parameters:
- DWIDTH, 32, signed weight/feature data width.
- KDIM, 3, kernel taps; odd, 1..15.
- DIMW, 16, width of dimension/row-count config fields.
- ACCW, 2*DWIDTH+4, accumulator/output width; must be >= 2*DWIDTH+clog2(KDIM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE.
- cfg_fm_dim  in  DIMW  row length L (>=1); latched on start.
- cfg_rows  in  DIMW  rows to process per job (>=1); latched on start.
- cfg_pad  in  1  1: P=(KDIM-1)/2 zeros each side of row; 0: P=0; latched.
- cfg_stride2  in  1  1: stride 2, 0: stride 1; latched.
- wt_data  in  DWIDTH  weight w[k], k=0..KDIM-1 in order.
- wt_valid  in  1  weight valid.
- wt_ready  out  1  weight accepted when wt_valid&wt_ready.
- fm_data  in  DWIDTH  feature sample, row-major.
- fm_valid  in  1  feature valid.
- fm_ready  out  1  feature accepted when fm_valid&fm_ready.
- out_data  out  ACCW  y[j] = sum_k w[k]*x[j*S+k-P], x outside row = 0.
- out_valid  out  1  output valid.
- out_ready  in  1  output consumer ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after last output of job handshakes.

Behaviour:
- Reset (async assert, sync deassert by top): state IDLE; wt_ready=0, fm_ready=0, out_valid=0, out_data=0, busy=0, done=0; weights, window and counters cleared.
- FSM: IDLE -> LOAD_W on cfg_start (config latched same edge). LOAD_W: wt_ready=1; tap counter 0..KDIM-1; on handshake with counter==KDIM-1 -> ROW_INIT. ROW_INIT (1 cycle): window cleared to 0, pos=0, phase=0 -> STREAM. STREAM: feeds Leff=L+2P positions. Positions 0..P-1 and L+P..Leff-1 are halo: 0 shifted in internally, no fm handshake, fm_ready=0. Positions P..L+P-1 need an fm handshake. After position Leff-1 shifts: if rows remaining -> ROW_INIT, else -> DRAIN. DRAIN waits for out_valid=0 -> IDLE with done=1 for one cycle.
- Window: KDIM-entry shift register; each advance shifts the new sample in at tap KDIM-1 and moves older ones toward tap 0.
- Emit rule: after an advance at position p>=KDIM-1, an output is due when (p-(KDIM-1)) mod S == 0. Phase counter resets per row.
- Outputs per row = floor((Leff-KDIM)/S)+1 if Leff>=KDIM, else 0. A row with zero outputs still consumes L samples and completes normally.
- MAC: signed DWIDTH x DWIDTH products, sign-extended to ACCW and summed combinationally from the window. The result is registered into out_data on the advance edge, so out_valid rises 1 cycle after the completing advance. No saturation; ACCW guarantees no overflow.
- Backpressure: single output register. An advance (fm or halo) is permitted only if it will not emit, or out_valid=0, or out_ready=1 in the same cycle. Otherwise fm_ready=0 and halo stalls. Simultaneous pop and new emit keeps out_valid=1 with new data.
- out_data holds while out_valid & ~out_ready.
- wt_ready=0 and fm_ready=0 outside their states; inputs ignored there.
- cfg_start while busy is ignored.
- Weights persist across rows of a job; a new job always reloads weights.
- Reset mid-operation: immediate return to reset values; pending output discarded.

Decomposition:
- Shared accelerator package: state encoding (IDLE, LOAD_W, ROW_INIT, STREAM, DRAIN), ACCW derivation, clog2 function.
- Sub-module: conv_mac_tree (combinational KDIM-way signed multiply + adder tree, params DWIDTH/KDIM/ACCW), reusable by other PE variants.
- Control and window stay in conv_row_pe_v2 using existing REGISTER_R_CE cells.

Test Plan:
- KDIM=3, w=[1,2,3], L=4, x=[1,2,3,4], pad=1, stride1, out_ready=1 -> outputs 8,14,20,11; done pulse after 4th handshake.
- Same weights/input, pad=0 -> outputs 14,20 only. Pad=1, stride2 -> outputs 8,20.
- Signed: w=[-1,0,1], L=2, x=[5,-3], pad=1 -> outputs -3,-5 (sign-extended full ACCW).
- Backpressure: first case with out_ready low for 5 cycles after first out_valid -> out_data holds 8, fm_ready=0 during stall, no sample lost, final sequence still 8,14,20,11.
- Multi-row/edge: cfg_rows=2, rows [1,2,3,4],[4,3,2,1], pad=0 -> 14,20 then 16,10; window cleared between rows. Then L=2, pad=0 -> zero outputs, 2 fm handshakes, done asserts.
- Reset and config guard: rst_n asserted mid-STREAM with out_valid=1 -> all outputs 0 same cycle. After release, a full job runs correctly. cfg_start while busy has no effect.

Source files
------------

// File: rtl/conv_row_pe_v2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_row_pe_v2_pkg : shared conv-accelerator types, widths and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package conv_row_pe_v2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_W   = 3'd1,
      ST_ROW_INIT = 3'd2,
      ST_STREAM   = 3'd3,
      ST_DRAIN    = 3'd4
   } state_t;

   // Headroom bits added on top of a full product; covers sums of up to 16 taps.
   localparam int ACC_GUARD = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

   function automatic int min_accw(input int dwidth, input int kdim);
      return 2 * dwidth + clog2(kdim);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_row_pe_v2_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_row_pe_v2_if : weight / feature / result ready-valid bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface conv_row_pe_v2_if #(
   parameter int DWIDTH = 32,
   parameter int ACCW   = 2 * DWIDTH + 4
);
   logic [DWIDTH-1:0] wt_data;
   logic              wt_valid;
   logic              wt_ready;
   logic [DWIDTH-1:0] fm_data;
   logic              fm_valid;
   logic              fm_ready;
   logic [ACCW-1:0]   out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output wt_data, wt_valid, fm_data, fm_valid, out_ready,
      input  wt_ready, fm_ready, out_data, out_valid
   );

   modport slave (
      input  wt_data, wt_valid, fm_data, fm_valid, out_ready,
      output wt_ready, fm_ready, out_data, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/conv_row_pe_v2_mac_tree.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_mac_tree : combinational KDIM-way signed multiply and sum
// Rev 1.0
// ----------------------------------------------------------------------------
module conv_mac_tree #(
   parameter int DWIDTH = 32,
   parameter int KDIM   = 3,
   parameter int ACCW   = 2 * DWIDTH + 4
) (
   input  logic [KDIM-1:0][DWIDTH-1:0] wt_i,
   input  logic [KDIM-1:0][DWIDTH-1:0] win_i,
   output logic signed [ACCW-1:0]      sum_o
);
   logic signed [ACCW-1:0] prod [KDIM];

   for (genvar k = 0; k < KDIM; k++) begin : g_tap
      logic signed [2*DWIDTH-1:0] p;
      // Operands are widened first so the multiply keeps the full signed product.
      assign p = $signed({{DWIDTH{wt_i[k][DWIDTH-1]}}, wt_i[k]})
               * $signed({{DWIDTH{win_i[k][DWIDTH-1]}}, win_i[k]});
      assign prod[k] = ACCW'(p);
   end

   always_comb begin
      sum_o = '0;
      for (int k = 0; k < KDIM; k++) begin
         sum_o = sum_o + prod[k];
      end
   end
endmodule
`default_nettype wire

// File: rtl/conv_row_pe_v2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_row_pe_v2 : one kernel-row PE, padded/strided row convolution stream
// Rev 1.0
// ----------------------------------------------------------------------------
module conv_row_pe_v2
   import conv_row_pe_v2_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int KDIM   = 3,
   parameter int DIMW   = 16,
   parameter int ACCW   = 2 * DWIDTH + ACC_GUARD
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_start_i,
   input  logic [DIMW-1:0] cfg_fm_dim_i,
   input  logic [DIMW-1:0] cfg_rows_i,
   input  logic            cfg_pad_i,
   input  logic            cfg_stride2_i,
   conv_row_pe_v2_if.slave io,
   output logic            busy_o,
   output logic            done_o
);
   localparam int TAPW = (KDIM > 1) ? clog2(KDIM) : 1;
   localparam int POSW = DIMW + 1;
   localparam int HALO = (KDIM - 1) / 2;

   state_t                      state_q, state_d;
   logic [KDIM-1:0][DWIDTH-1:0] wt_q, wt_d;
   logic [KDIM-1:0][DWIDTH-1:0] win_q, win_d, win_shift;
   logic [TAPW-1:0]             tap_q, tap_d;
   logic [DIMW-1:0]             len_q, len_d;
   logic [DIMW-1:0]             rows_q, rows_d;
   logic                        pad_q, pad_d;
   logic                        s2_q, s2_d;
   logic [POSW-1:0]             pos_q, pos_d;
   logic                        phase_q, phase_d;
   logic [ACCW-1:0]             out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic                        done_q, done_d;

   logic [POSW-1:0]        pad_w, len_w, leff;
   logic                   is_halo, at_tail, emit, can_adv, advance;
   logic                   wt_ready, fm_ready;
   logic [DWIDTH-1:0]      new_sample;
   logic signed [ACCW-1:0] mac_sum;

   assign pad_w   = pad_q ? POSW'(HALO) : '0;
   assign len_w   = POSW'(len_q);
   assign leff    = len_w + (pad_w << 1);
   assign is_halo = (pos_q < pad_w) || (pos_q >= len_w + pad_w);
   assign at_tail = (pos_q >= POSW'(KDIM - 1));
   assign emit    = at_tail && (!s2_q || !phase_q);
   // The single output slot must be free, or freed this cycle, before an emitting shift.
   assign can_adv = !emit || !out_valid_q || io.out_ready;
   assign advance = (state_q == ST_STREAM) && can_adv && (is_halo || io.fm_valid);
   assign new_sample = is_halo ? '0 : io.fm_data;

   always_comb begin
      win_shift = win_q;
      for (int k = 0; k < KDIM - 1; k++) begin
         win_shift[k] = win_q[k+1];
      end
      win_shift[KDIM-1] = new_sample;
   end

   conv_mac_tree #(
      .DWIDTH (DWIDTH),
      .KDIM   (KDIM),
      .ACCW   (ACCW)
   ) u_mac (
      .wt_i   (wt_q),
      .win_i  (win_shift),
      .sum_o  (mac_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      wt_d        = wt_q;
      tap_d       = tap_q;
      len_d       = len_q;
      rows_d      = rows_q;
      pad_d       = pad_q;
      s2_d        = s2_q;
      win_d       = win_q;
      pos_d       = pos_q;
      phase_d     = phase_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      wt_ready    = 1'b0;
      fm_ready    = 1'b0;

      if (out_valid_q && io.out_ready) out_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start_i) begin
               len_d   = cfg_fm_dim_i;
               rows_d  = cfg_rows_i;
               pad_d   = cfg_pad_i;
               s2_d    = cfg_stride2_i;
               tap_d   = '0;
               state_d = ST_LOAD_W;
            end
         end
         ST_LOAD_W: begin
            wt_ready = 1'b1;
            if (io.wt_valid) begin
               wt_d[tap_q] = io.wt_data;
               tap_d       = tap_q + TAPW'(1);
               if (tap_q == TAPW'(KDIM - 1)) state_d = ST_ROW_INIT;
            end
         end
         ST_ROW_INIT: begin
            win_d   = '0;
            pos_d   = '0;
            phase_d = 1'b0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            fm_ready = !is_halo && can_adv;
            if (advance) begin
               win_d = win_shift;
               pos_d = pos_q + POSW'(1);
               if (at_tail) phase_d = ~phase_q;
               if (emit) begin
                  out_valid_d = 1'b1;
                  out_data_d  = mac_sum;
               end
               if (pos_q == leff - POSW'(1)) begin
                  if (rows_q > DIMW'(1)) begin
                     rows_d  = rows_q - DIMW'(1);
                     state_d = ST_ROW_INIT;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (!out_valid_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wt_q        <= '0;
         win_q       <= '0;
         tap_q       <= '0;
         len_q       <= '0;
         rows_q      <= '0;
         pad_q       <= 1'b0;
         s2_q        <= 1'b0;
         pos_q       <= '0;
         phase_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         wt_q        <= wt_d;
         win_q       <= win_d;
         tap_q       <= tap_d;
         len_q       <= len_d;
         rows_q      <= rows_d;
         pad_q       <= pad_d;
         s2_q        <= s2_d;
         pos_q       <= pos_d;
         phase_q     <= phase_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign io.wt_ready  = wt_ready;
   assign io.fm_ready  = fm_ready;
   assign io.out_data  = out_data_q;
   assign io.out_valid = out_valid_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_row_pe_v2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_row_pe_v2 : directed table-driven bench for conv_row_pe_v2 (KDIM=3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_conv_row_pe_v2;
   localparam int DW     = 32;
   localparam int KD     = 3;
   localparam int DIMW   = 16;
   localparam int AW     = 2 * DW + 4;
   localparam int BUDGET = 400;
   localparam int NVEC   = 7;

   typedef struct packed {
      int               len;
      int               rows;
      int               pad;
      int               s2;
      logic [0:2][31:0] w;
      logic [0:7][31:0] x;
      int               nout;
      logic [0:7][31:0] y;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            cfg_start_i = 1'b0;
   logic [DIMW-1:0] cfg_fm_dim_i = '0;
   logic [DIMW-1:0] cfg_rows_i = '0;
   logic            cfg_pad_i = 1'b0;
   logic            cfg_stride2_i = 1'b0;
   logic            busy_o;
   logic            done_o;
   int              n_cmp = 0;
   int              n_fail = 0;
   vec_t            tbl [NVEC];

   conv_row_pe_v2_if #(.DWIDTH(DW), .ACCW(AW)) bus ();

   conv_row_pe_v2 #(
      .DWIDTH (DW),
      .KDIM   (KD),
      .DIMW   (DIMW),
      .ACCW   (AW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start_i   (cfg_start_i),
      .cfg_fm_dim_i  (cfg_fm_dim_i),
      .cfg_rows_i    (cfg_rows_i),
      .cfg_pad_i     (cfg_pad_i),
      .cfg_stride2_i (cfg_stride2_i),
      .io            (bus),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no handshake within %0d cycles", nm, BUDGET);
   endtask

   task automatic start_job(input vec_t v, input bit poke, output bit ok);
      @(posedge clk); #1;
      cfg_fm_dim_i  = DIMW'(v.len);
      cfg_rows_i    = DIMW'(v.rows);
      cfg_pad_i     = v.pad[0];
      cfg_stride2_i = v.s2[0];
      cfg_start_i   = 1'b1;
      @(posedge clk); #1;
      cfg_start_i = 1'b0;
      chki("busy_after_start", int'(busy_o), 1);
      ok = 1'b1;
      for (int k = 0; k < KD && ok; k++) begin
         bit seen;
         seen = 1'b0;
         bus.wt_valid = 1'b1;
         bus.wt_data  = v.w[k];
         for (int c = 0; c < BUDGET && !seen; c++) begin
            @(negedge clk);
            seen = bus.wt_ready;
         end
         if (!seen) begin
            timeout("wt_handshake");
            ok = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      bus.wt_valid = 1'b0;
      if (ok && poke) begin
         // A start with different config while busy must change nothing.
         cfg_fm_dim_i  = 16'd7;
         cfg_pad_i     = ~cfg_pad_i;
         cfg_stride2_i = ~cfg_stride2_i;
         cfg_start_i   = 1'b1;
         @(posedge clk); #1;
         cfg_start_i = 1'b0;
         chki("busy_during_poke", int'(busy_o), 1);
      end
   endtask

   task automatic run_job(input vec_t v, input int stall, input bit poke, input int id);
      bit ok;
      bit dseen;
      int nsamp;
      int acc;
      int extra;
      nsamp = v.rows * v.len;
      acc   = 0;
      extra = 0;
      start_job(v, poke, ok);
      if (!ok) return;
      if (stall > 0) bus.out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < nsamp; i++) begin
               bit seen;
               seen = 1'b0;
               bus.fm_valid = 1'b1;
               bus.fm_data  = v.x[i];
               for (int c = 0; c < BUDGET && !seen; c++) begin
                  @(negedge clk);
                  seen = bus.fm_ready;
               end
               if (!seen) begin
                  timeout($sformatf("job%0d_fm_handshake", id));
                  break;
               end
               acc++;
               @(posedge clk); #1;
            end
            bus.fm_valid = 1'b0;
         end
         begin
            if (stall > 0) begin
               bit vs;
               vs = 1'b0;
               for (int c = 0; c < BUDGET && !vs; c++) begin
                  @(negedge clk);
                  vs = bus.out_valid;
               end
               if (!vs) timeout($sformatf("job%0d_first_valid", id));
               for (int s = 0; s < stall && vs; s++) begin
                  chk($sformatf("job%0d_stall_hold", id), bus.out_data, AW'($signed(v.y[0])));
                  chki($sformatf("job%0d_stall_fm_ready", id), int'(bus.fm_ready), 0);
                  if (s < stall - 1) @(negedge clk);
               end
               @(posedge clk); #1;
               bus.out_ready = 1'b1;
            end
            for (int j = 0; j < v.nout; j++) begin
               bit seen;
               seen = 1'b0;
               for (int c = 0; c < BUDGET && !seen; c++) begin
                  @(negedge clk);
                  seen = bus.out_valid && bus.out_ready;
               end
               if (!seen) begin
                  timeout($sformatf("job%0d_y%0d", id, j));
                  break;
               end
               chk($sformatf("job%0d_y%0d", id, j), bus.out_data, AW'($signed(v.y[j])));
               @(posedge clk); #1;
            end
         end
      join
      chki($sformatf("job%0d_fm_count", id), acc, nsamp);
      dseen = 1'b0;
      for (int c = 0; c < BUDGET && !dseen; c++) begin
         @(negedge clk);
         if (bus.out_valid) extra++;
         dseen = done_o;
      end
      chki($sformatf("job%0d_done_seen", id), int'(dseen), 1);
      chki($sformatf("job%0d_extra_outputs", id), extra, 0);
      @(negedge clk);
      chki($sformatf("job%0d_done_width", id), int'(done_o), 0);
      chki($sformatf("job%0d_idle", id), int'(busy_o), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      bit seen;
      bus.wt_valid  = 1'b0;
      bus.wt_data   = '0;
      bus.fm_valid  = 1'b0;
      bus.fm_data   = '0;
      bus.out_ready = 1'b1;

      tbl[0] = '{len:4, rows:1, pad:1, s2:0, w:'{1, 2, 3}, x:'{1, 2, 3, 4, 0, 0, 0, 0},
                 nout:4, y:'{8, 14, 20, 11, 0, 0, 0, 0}};
      tbl[1] = '{len:4, rows:1, pad:0, s2:0, w:'{1, 2, 3}, x:'{1, 2, 3, 4, 0, 0, 0, 0},
                 nout:2, y:'{14, 20, 0, 0, 0, 0, 0, 0}};
      tbl[2] = '{len:4, rows:1, pad:1, s2:1, w:'{1, 2, 3}, x:'{1, 2, 3, 4, 0, 0, 0, 0},
                 nout:2, y:'{8, 20, 0, 0, 0, 0, 0, 0}};
      tbl[3] = '{len:2, rows:1, pad:1, s2:0, w:'{-1, 0, 1}, x:'{5, -3, 0, 0, 0, 0, 0, 0},
                 nout:2, y:'{-3, -5, 0, 0, 0, 0, 0, 0}};
      tbl[4] = '{len:4, rows:2, pad:0, s2:0, w:'{1, 2, 3}, x:'{1, 2, 3, 4, 4, 3, 2, 1},
                 nout:4, y:'{14, 20, 16, 10, 0, 0, 0, 0}};
      tbl[5] = '{len:2, rows:1, pad:0, s2:0, w:'{1, 2, 3}, x:'{7, 9, 0, 0, 0, 0, 0, 0},
                 nout:0, y:'{0, 0, 0, 0, 0, 0, 0, 0}};
      tbl[6] = '{len:5, rows:1, pad:0, s2:1, w:'{1, 2, 3}, x:'{1, 2, 3, 4, 5, 0, 0, 0},
                 nout:2, y:'{14, 26, 0, 0, 0, 0, 0, 0}};

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_data", bus.out_data, '0);
      chki("rst_out_valid", int'(bus.out_valid), 0);
      chki("rst_wt_ready", int'(bus.wt_ready), 0);
      chki("rst_fm_ready", int'(bus.fm_ready), 0);
      chki("rst_busy", int'(busy_o), 0);
      chki("rst_done", int'(done_o), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int t = 0; t < NVEC; t++) begin
         run_job(tbl[t], 0, 1'b0, t);
      end

      run_job(tbl[0], 5, 1'b0, 10);
      run_job(tbl[1], 0, 1'b1, 11);

      // Reset while a result is parked in the output register.
      start_job(tbl[0], 1'b0, ok);
      bus.out_ready = 1'b0;
      bus.fm_valid  = 1'b1;
      bus.fm_data   = 32'd1;
      seen = 1'b0;
      for (int c = 0; c < BUDGET && !seen; c++) begin
         @(negedge clk);
         seen = bus.out_valid;
      end
      chki("midrst_pre_valid", int'(seen), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_data", bus.out_data, '0);
      chki("midrst_out_valid", int'(bus.out_valid), 0);
      chki("midrst_busy", int'(busy_o), 0);
      chki("midrst_done", int'(done_o), 0);
      chki("midrst_fm_ready", int'(bus.fm_ready), 0);
      chki("midrst_wt_ready", int'(bus.wt_ready), 0);
      bus.fm_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_job(tbl[0], 0, 1'b0, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
